multicycle_controller: RTL and testbench

- Multi-cycle sequencer for the ARM-subset core.
- Consumes the decoded instruction fields and the ALU flags, holds the architectural NZCV register, and evaluates condition codes.
- Steps each instruction through fetch, decode, execute, memory and writeback, driving the enables for the PC, instruction register, register file, data memory and flags.
- Sits between the instruction decoder and the datapath/memory interfaces.

---
 rtl/controller_pkg.sv | 42 ++++
 rtl/cond_check.sv | 38 +++
 rtl/multicycle_controller.sv | 209 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/controller_pkg.sv
// Shared types and constants for the multi-cycle ARM-subset controller.
package controller_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXECUTE,
    MEMADDR,
    MEMRD,
    MEMWB,
    MEMWR,
    BRANCH
  } state_t;

  localparam logic [1:0] TYPE_DP  = 2'b00;
  localparam logic [1:0] TYPE_MEM = 2'b01;
  localparam logic [1:0] TYPE_BR  = 2'b10;
  localparam logic [1:0] TYPE_UND = 2'b11;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluation against the current NZCV flags.
module cond_check
  import controller_pkg::*;
(
  input  logic [3:0] condition,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    pass = 1'b0;
    case (condition)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer holding NZCV.
// Optional retired/skipped instruction counters under CONTROLLER_PERF_EN.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  insType,
  input  logic        immFlag,
  input  logic        setFlags,
  input  logic [4:0]  loadStoreSignals,
  input  logic [3:0]  condition,
  input  logic [3:0]  aluFlags,
  input  logic        instrReady,
  input  logic        dataReady,
  output logic        instrReq,
  output logic        dataReq,
  output logic        cntrlIrWrite,
  output logic        cntrlPcWrite,
  output logic        cntrlPcSrc,
  output logic        cntrlAluSrc,
  output logic        cntrlRegWrite,
  output logic        cntrlMemWrite,
  output logic        cntrlMemtoReg,
  output logic [3:0]  flags,
  output logic        illegal,
  output logic        busy
`ifdef CONTROLLER_PERF_EN
  ,
  output logic [31:0] retiredCount,
  output logic [31:0] skippedCount
`endif
);

  localparam int unsigned CNT_W      = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);

  state_t            state, state_next;
  logic [3:0]        flag_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              cond_pass;
  logic              in_wait_state, waiting, timeout_hit;
  logic              flags_load, retire, skip;

  cond_check u_cond_check (
    .condition (condition),
    .flags     (flag_q),
    .pass      (cond_pass)
  );

  // Timeout wins over a ready arriving in the same cycle; the access is dropped.
  always_comb begin
    in_wait_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
    timeout_hit   = TIMEOUT_EN && in_wait_state && (wait_cnt == CNT_W'(MEM_TIMEOUT));
    waiting       = !timeout_hit &&
                    (((state == FETCH) && !instrReady) ||
                     ((state == MEMRD) && !dataReady)  ||
                     ((state == MEMWR) && !dataReady));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = state;
    instrReq      = 1'b0;
    dataReq       = 1'b0;
    cntrlIrWrite  = 1'b0;
    cntrlPcWrite  = 1'b0;
    cntrlPcSrc    = 1'b0;
    cntrlAluSrc   = 1'b0;
    cntrlRegWrite = 1'b0;
    cntrlMemWrite = 1'b0;
    cntrlMemtoReg = 1'b0;
    illegal       = 1'b0;
    busy          = (state != FETCH);
    flags_load    = 1'b0;
    retire        = 1'b0;
    skip          = 1'b0;
    case (state)
      FETCH: begin
        if (timeout_hit) begin
          illegal = 1'b1;
        end else begin
          instrReq = 1'b1;
          if (instrReady) begin
            cntrlIrWrite = 1'b1;
            cntrlPcWrite = 1'b1;
            state_next   = DECODE;
          end
        end
      end
      DECODE: begin
        state_next = FETCH;
        if (!cond_pass) begin
          skip = 1'b1;
        end else begin
          case (insType)
            TYPE_DP:  state_next = EXECUTE;
            TYPE_MEM: state_next = MEMADDR;
            TYPE_BR:  state_next = BRANCH;
            default:  illegal    = 1'b1;
          endcase
        end
      end
      EXECUTE: begin
        cntrlAluSrc   = immFlag;
        cntrlRegWrite = 1'b1;
        flags_load    = setFlags;
        retire        = 1'b1;
        state_next    = FETCH;
      end
      MEMADDR: begin
        cntrlAluSrc = immFlag;
        state_next  = loadStoreSignals[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        if (timeout_hit) begin
          illegal    = 1'b1;
          state_next = FETCH;
        end else begin
          dataReq = 1'b1;
          if (dataReady) state_next = MEMWB;
        end
      end
      MEMWB: begin
        cntrlRegWrite = 1'b1;
        cntrlMemtoReg = 1'b1;
        retire        = 1'b1;
        state_next    = FETCH;
      end
      MEMWR: begin
        if (timeout_hit) begin
          illegal    = 1'b1;
          state_next = FETCH;
        end else begin
          dataReq       = 1'b1;
          cntrlMemWrite = 1'b1;
          if (dataReady) begin
            retire     = 1'b1;
            state_next = FETCH;
          end
        end
      end
      BRANCH: begin
        cntrlPcWrite = 1'b1;
        cntrlPcSrc   = 1'b1;
        retire       = 1'b1;
        state_next   = FETCH;
      end
      default: state_next = FETCH;
    endcase
    // Outputs are held quiet while reset is asserted.
    if (rst) begin
      instrReq      = 1'b0;
      dataReq       = 1'b0;
      cntrlIrWrite  = 1'b0;
      cntrlPcWrite  = 1'b0;
      cntrlPcSrc    = 1'b0;
      cntrlAluSrc   = 1'b0;
      cntrlRegWrite = 1'b0;
      cntrlMemWrite = 1'b0;
      cntrlMemtoReg = 1'b0;
      illegal       = 1'b0;
      busy          = 1'b0;
      flags_load    = 1'b0;
      retire        = 1'b0;
      skip          = 1'b0;
    end
  end

  // Wait counter restarts on any state change, including a timeout back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  wait_cnt <= '0;
    else if (timeout_hit || state_next != state) wait_cnt <= '0;
    else if (TIMEOUT_EN && waiting)           wait_cnt <= wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             flag_q <= RESET_FLAGS;
    else if (flags_load) flag_q <= aluFlags;
  end

  assign flags = flag_q;

`ifdef CONTROLLER_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retiredCount <= '0;
      skippedCount <= '0;
    end else begin
      if (retire) retiredCount <= retiredCount + 32'd1;
      if (skip)   skippedCount <= skippedCount + 32'd1;
    end
  end

  logic unused_ls;
  assign unused_ls = ^loadStoreSignals[4:1];
`else
  logic unused_sigs;
  assign unused_sigs = retire ^ skip ^ (^loadStoreSignals[4:1]);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: driver queues the hand-computed output vector of every cycle, monitor checks it.
module tb_multicycle_controller;

  typedef struct {
    logic [14:0] val;
    string       tag;
  } exp_t;

  localparam logic [14:0] IREQ = 15'h4000;
  localparam logic [14:0] DREQ = 15'h2000;
  localparam logic [14:0] IRW  = 15'h1000;
  localparam logic [14:0] PCW  = 15'h0800;
  localparam logic [14:0] PCS  = 15'h0400;
  localparam logic [14:0] ALU  = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] MW   = 15'h0080;
  localparam logic [14:0] M2R  = 15'h0040;
  localparam logic [14:0] ILL  = 15'h0020;
  localparam logic [14:0] BSY  = 15'h0010;
  localparam logic [14:0] F4   = 15'h0004;
  localparam logic [14:0] FH   = IREQ | IRW | PCW;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ins_type;
  logic        imm_flag, set_flags;
  logic [4:0]  ls_sig;
  logic [3:0]  cond;
  logic [3:0]  alu_flags;
  logic        instr_ready, data_ready;
  logic        instr_req, data_req, ir_write, pc_write, pc_src, alu_src;
  logic        reg_write, mem_write, mem_to_reg, illegal, busy;
  logic [3:0]  flags;
`ifdef CONTROLLER_PERF_EN
  logic [31:0] retired_count, skipped_count;
`endif

  exp_t  sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    exp_ret = 0;
  int    exp_skip = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_TIMEOUT(16), .RESET_FLAGS(4'b0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .insType          (ins_type),
    .immFlag          (imm_flag),
    .setFlags         (set_flags),
    .loadStoreSignals (ls_sig),
    .condition        (cond),
    .aluFlags         (alu_flags),
    .instrReady       (instr_ready),
    .dataReady        (data_ready),
    .instrReq         (instr_req),
    .dataReq          (data_req),
    .cntrlIrWrite     (ir_write),
    .cntrlPcWrite     (pc_write),
    .cntrlPcSrc       (pc_src),
    .cntrlAluSrc      (alu_src),
    .cntrlRegWrite    (reg_write),
    .cntrlMemWrite    (mem_write),
    .cntrlMemtoReg    (mem_to_reg),
    .flags            (flags),
    .illegal          (illegal),
    .busy             (busy)
`ifdef CONTROLLER_PERF_EN
    ,
    .retiredCount     (retired_count),
    .skippedCount     (skipped_count)
`endif
  );

  // Monitor: one expected vector per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [14:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {instr_req, data_req, ir_write, pc_write, pc_src, alu_src, reg_write,
             mem_write, mem_to_reg, illegal, busy, flags};
      vectors++;
      if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.tag, act, e.val);
      end
    end
  end

  task automatic set_instr(input logic [1:0] t, input logic i, input logic s,
                           input logic [4:0] ls, input logic [3:0] c, input logic [3:0] af);
    ins_type = t; imm_flag = i; set_flags = s; ls_sig = ls; cond = c; alu_flags = af;
  endtask

  task automatic step(input logic ir, input logic dr, input logic [14:0] e, input string tag);
    exp_t x;
    instr_ready = ir;
    data_ready  = dr;
    x.val = e;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] conds [4];
    logic       passes [4];
    conds  = '{4'b1100, 4'b1101, 4'b1111, 4'b0011};
    passes = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    set_instr(2'b00, 1'b0, 1'b0, 5'b0, 4'b1110, 4'b0000);
    instr_ready = 1'b0;
    data_ready  = 1'b0;
    @(posedge clk);
    #1;
    step(0, 0, 15'h0, "reset0");
    step(0, 0, 15'h0, "reset1");
    rst = 1'b0;
    step(0, 0, IREQ, "fetch_idle");

    // ADD, S=0: flags must ignore aluFlags
    set_instr(2'b00, 1'b0, 1'b0, 5'b0, 4'b1110, 4'b1111);
    step(1, 0, FH,       "add_fetch");
    step(0, 0, BSY,      "add_decode");
    step(0, 0, BSY | RW, "add_exec");
    exp_ret++;

    // SUBS I=1 -> Z set
    set_instr(2'b00, 1'b1, 1'b1, 5'b0, 4'b1110, 4'b0100);
    step(1, 0, FH,             "subs_fetch");
    step(0, 0, BSY,            "subs_decode");
    step(0, 0, BSY | ALU | RW, "subs_exec");
    exp_ret++;

    set_instr(2'b10, 1'b0, 1'b0, 5'b0, 4'b0000, 4'b1111);
    step(1, 0, FH | F4,              "beq_fetch");
    step(0, 0, BSY | F4,             "beq_decode");
    step(0, 0, BSY | PCW | PCS | F4, "beq_branch");
    exp_ret++;

    set_instr(2'b10, 1'b0, 1'b0, 5'b0, 4'b0001, 4'b1111);
    step(1, 0, FH | F4,  "bne_fetch");
    step(0, 0, BSY | F4, "bne_decode");
    exp_skip++;

    // Condition table with flags = 0100: GT fail, LE pass, NV fail, CC pass
    for (int i = 0; i < 4; i++) begin
      set_instr(2'b10, 1'b0, 1'b0, 5'b0, conds[i], 4'b0000);
      step(1, 0, FH | F4,  $sformatf("cond%0d_fetch", i));
      step(0, 0, BSY | F4, $sformatf("cond%0d_decode", i));
      if (passes[i]) begin
        step(0, 0, BSY | PCW | PCS | F4, $sformatf("cond%0d_branch", i));
        exp_ret++;
      end else begin
        exp_skip++;
      end
    end

    // Load with three wait cycles
    set_instr(2'b01, 1'b1, 1'b0, 5'b00001, 4'b1110, 4'b0000);
    step(1, 0, FH | F4,        "ld_fetch");
    step(0, 0, BSY | F4,       "ld_decode");
    step(0, 0, BSY | ALU | F4, "ld_memaddr");
    for (int i = 0; i < 3; i++) step(0, 0, BSY | DREQ | F4, $sformatf("ld_wait%0d", i));
    step(0, 1, BSY | DREQ | F4,     "ld_ready");
    step(0, 0, BSY | RW | M2R | F4, "ld_wb");
    exp_ret++;

    // Reset asserted in the middle of MEMRD
    step(1, 0, FH | F4,        "ld2_fetch");
    step(0, 0, BSY | F4,       "ld2_decode");
    step(0, 0, BSY | ALU | F4, "ld2_memaddr");
    step(0, 0, BSY | DREQ | F4, "ld2_memrd");
    rst = 1'b1;
    step(0, 0, 15'h0, "rst_mid_memrd");
    exp_ret  = 0;
    exp_skip = 0;
    rst = 1'b0;
    step(0, 0, IREQ, "post_rst_fetch");

    // Store with dataReady never arriving
    set_instr(2'b01, 1'b0, 1'b0, 5'b00000, 4'b1110, 4'b0000);
    step(1, 0, FH,  "st_fetch");
    step(0, 0, BSY, "st_decode");
    step(0, 0, BSY, "st_memaddr");
    for (int i = 0; i < 16; i++) step(0, 0, BSY | DREQ | MW, $sformatf("st_wait%0d", i));
    step(0, 0, BSY | ILL, "st_timeout");
    step(0, 0, IREQ,      "st_after");

    // Undefined type, then instruction memory stalls into a fetch timeout
    set_instr(2'b11, 1'b0, 1'b0, 5'b0, 4'b1110, 4'b0000);
    step(1, 0, FH,        "und_fetch");
    step(0, 0, BSY | ILL, "und_decode");
    step(0, 0, IREQ,      "fetch_wait0");
    for (int i = 1; i < 16; i++) step(0, 0, IREQ, $sformatf("fetch_wait%0d", i));
    step(0, 0, ILL,  "fetch_timeout");
    step(0, 0, IREQ, "fetch_restart");

    // Zero-wait store completes
    set_instr(2'b01, 1'b0, 1'b0, 5'b00000, 4'b1110, 4'b0000);
    step(1, 0, FH,              "st2_fetch");
    step(0, 0, BSY,             "st2_decode");
    step(0, 0, BSY,             "st2_memaddr");
    step(0, 1, BSY | DREQ | MW, "st2_commit");
    exp_ret++;
    step(0, 0, IREQ,            "st2_after");

    @(negedge clk);
    #1;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
`ifdef CONTROLLER_PERF_EN
    vectors++;
    if (retired_count !== 32'(exp_ret)) begin
      miscompares++;
      $display("FAIL retired_count: got %0d expected %0d", retired_count, exp_ret);
    end
    vectors++;
    if (skipped_count !== 32'(exp_skip)) begin
      miscompares++;
      $display("FAIL skipped_count: got %0d expected %0d", skipped_count, exp_skip);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
